spi_ram_burst_slave: RTL

Parametrised successor to the team's SPI-slave plus single-port-RAM wrapper. A serial command stream (MOSI/SS_n, sampled on the system clock) writes and reads an embedded MEM_DEPTH x DATA_WIDTH memory. New relative to the previous generation:
- generic data and address widths;
- separate write and read address pointers with optional post-increment (burst) and wrap-around;
- back-to-back frames within one SS_n assertion;
- an abort/error indication.

---
 rtl/spi_ram_burst_slave.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/spi_ram_burst_slave.sv
// Bit-serial command slave in front of a MEM_DEPTH x DATA_WIDTH RAM: 2 command bits plus
// DATA_WIDTH payload bits per frame, MSB first, sampled on clk while SS_n is low.
module spi_ram_burst_slave #(
    parameter int DATA_WIDTH = 8,
    parameter int MEM_DEPTH  = 256,
    parameter int ADDR_WIDTH = $clog2(MEM_DEPTH),
    parameter int AUTO_INC   = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic SS_n,
    input  logic MOSI,
    output logic MISO,
    output logic busy,
    output logic frame_err
);
    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(DATA_WIDTH - 1);
    localparam logic [ADDR_WIDTH-1:0] PTR_LAST = ADDR_WIDTH'(MEM_DEPTH - 1);
    localparam logic [1:0] CMD_WPTR  = 2'b00;
    localparam logic [1:0] CMD_WRITE = 2'b01;
    localparam logic [1:0] CMD_RPTR  = 2'b10;
    localparam logic [1:0] CMD_READ  = 2'b11;

    typedef enum logic [2:0] {IDLE, CMD, PAYLOAD, EXEC, READ_OUT} state_t;

    state_t                  state_reg, state_next;
    logic                    abort;
    logic [CNT_W-1:0]        bit_cnt_reg;
    logic [1:0]              cmd_reg;
    logic [DATA_WIDTH-1:0]   data_reg;
    logic [DATA_WIDTH-1:0]   shift_reg;
    logic [ADDR_WIDTH-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic                    miso_reg, frame_err_reg;
    logic                    rd_oob_reg;
    logic [DATA_WIDTH-1:0]   mem_rd_reg;
    logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];
    logic                    wr_in_range, rd_in_range;
    logic                    mem_we, mem_re;
    logic                    cnt_last, cmd_done;

    // Only a non-power-of-two depth leaves pointer values with no backing word.
    generate
        if (MEM_DEPTH == (1 << ADDR_WIDTH)) begin : g_full_range
            assign wr_in_range = 1'b1;
            assign rd_in_range = 1'b1;
        end else begin : g_part_range
            assign wr_in_range = (wr_ptr_reg <= PTR_LAST);
            assign rd_in_range = (rd_ptr_reg <= PTR_LAST);
        end
    endgenerate

    function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] p);
        if (AUTO_INC == 0)
            return p;
        return (p == PTR_LAST) ? '0 : p + ADDR_WIDTH'(1);
    endfunction

    assign cnt_last = (bit_cnt_reg == CNT_LAST);
    assign cmd_done = (bit_cnt_reg == CNT_W'(1));

    always_ff @(posedge clk) begin
        if (rst)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        abort      = 1'b0;
        case (state_reg)
            IDLE:     if (!SS_n) state_next = CMD;
            CMD: begin
                if (SS_n) begin
                    state_next = IDLE;
                    abort      = 1'b1;
                end else if (cmd_done) begin
                    state_next = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (SS_n) begin
                    state_next = IDLE;
                    abort      = 1'b1;
                end else if (cnt_last) begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                if (cmd_reg == CMD_READ)
                    state_next = READ_OUT;
                else
                    state_next = SS_n ? IDLE : CMD;
            end
            READ_OUT: begin
                // The final bit always completes; SS_n only aborts earlier bits.
                if (cnt_last) begin
                    state_next = SS_n ? IDLE : CMD;
                end else if (SS_n) begin
                    state_next = IDLE;
                    abort      = 1'b1;
                end
            end
            default:  state_next = IDLE;
        endcase
    end

    // The RAM read is issued on the last payload edge so its data is registered by EXEC.
    assign mem_re = (state_reg == PAYLOAD) && !SS_n && cnt_last && (cmd_reg == CMD_READ);
    assign mem_we = (state_reg == EXEC) && (cmd_reg == CMD_WRITE) && wr_in_range;

    always_ff @(posedge clk) begin
        if (mem_we)
            mem[wr_ptr_reg] <= data_reg;
        if (mem_re)
            mem_rd_reg <= mem[rd_ptr_reg];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt_reg   <= '0;
            cmd_reg       <= '0;
            data_reg      <= '0;
            shift_reg     <= '0;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            miso_reg      <= 1'b0;
            frame_err_reg <= 1'b0;
            rd_oob_reg    <= 1'b0;
        end else begin
            frame_err_reg <= abort;
            miso_reg      <= 1'b0;
            if (mem_re)
                rd_oob_reg <= !rd_in_range;
            case (state_reg)
                CMD: begin
                    if (!SS_n) begin
                        cmd_reg     <= {cmd_reg[0], MOSI};
                        bit_cnt_reg <= cmd_done ? '0 : bit_cnt_reg + CNT_W'(1);
                    end else begin
                        bit_cnt_reg <= '0;
                    end
                end
                PAYLOAD: begin
                    if (!SS_n) begin
                        data_reg    <= {data_reg[DATA_WIDTH-2:0], MOSI};
                        bit_cnt_reg <= cnt_last ? '0 : bit_cnt_reg + CNT_W'(1);
                    end else begin
                        bit_cnt_reg <= '0;
                    end
                end
                EXEC: begin
                    bit_cnt_reg <= '0;
                    case (cmd_reg)
                        CMD_WPTR:  wr_ptr_reg <= data_reg[ADDR_WIDTH-1:0];
                        CMD_WRITE: wr_ptr_reg <= ptr_inc(wr_ptr_reg);
                        CMD_RPTR:  rd_ptr_reg <= data_reg[ADDR_WIDTH-1:0];
                        default: begin
                            shift_reg  <= rd_oob_reg ? '0 : mem_rd_reg;
                            rd_ptr_reg <= ptr_inc(rd_ptr_reg);
                        end
                    endcase
                end
                READ_OUT: begin
                    if (cnt_last || !SS_n) begin
                        miso_reg    <= shift_reg[DATA_WIDTH-1];
                        shift_reg   <= {shift_reg[DATA_WIDTH-2:0], 1'b0};
                        bit_cnt_reg <= cnt_last ? '0 : bit_cnt_reg + CNT_W'(1);
                    end else begin
                        bit_cnt_reg <= '0;
                    end
                end
                default:  bit_cnt_reg <= '0;
            endcase
        end
    end

    assign MISO      = miso_reg;
    assign frame_err = frame_err_reg;
    assign busy      = (state_reg != IDLE);

endmodule
